// File: rtl/instr_exec_unit_if.sv
// instr_exec_unit_if: instruction/debug/status bundle for instr_exec_unit
// master drives id, id_valid, rd_addr; slave (the unit) drives the rest.
interface instr_exec_unit_if #(parameter int DW = 8, parameter int NREG = 8);
  localparam int RAW = $clog2(NREG);
  localparam int IW = 4 + 2 * RAW + DW;
  logic [IW-1:0] id;
  logic id_valid;
  logic id_ready;
  logic [RAW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] acc;
  logic zero;
  logic carry;
  logic busy;
  logic halted;
  logic illegal;
  modport master(output id, id_valid, rd_addr, input id_ready, rd_data, acc, zero, carry, busy, halted, illegal);
  modport slave(input id, id_valid, rd_addr, output id_ready, rd_data, acc, zero, carry, busy, halted, illegal);
endinterface

// File: rtl/instr_exec_unit.sv
// instr_exec_unit: two-cycle accumulator/register-file instruction executor
// clk, rst (sync, active high); io_bus: id/id_valid/id_ready handshake,
// rd_addr/rd_data debug read, acc/zero/carry state, busy/halted/illegal status.
module instr_exec_unit #(parameter int DW = 8, parameter int NREG = 8) (
  input logic clk,
  input logic rst,
  instr_exec_unit_if.slave io_bus
);
  localparam int RAW = $clog2(NREG);
  localparam int IW = 4 + 2 * RAW + DW;
  typedef enum logic [1:0] {IDLE, EXEC, HALT} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_ir;
  logic [DW-1:0] r_regs [NREG];
  logic [DW-1:0] r_acc;
  logic r_zero, r_carry;
  logic [3:0] w_op;
  logic [RAW-1:0] w_dst, w_src;
  logic [DW-1:0] w_imm, w_s, w_acc, w_wd;
  logic [DW:0] w_sum, w_diff;
  logic w_we, w_zero, w_carry, w_upd_z;
  assign w_op = r_ir[IW-1 -: 4];
  assign w_dst = r_ir[IW-5 -: RAW];
  assign w_src = r_ir[IW-5-RAW -: RAW];
  assign w_imm = r_ir[DW-1:0];
  assign w_s = r_regs[w_src];
  assign w_sum = {1'b0, r_acc} + {1'b0, w_s};
  // MSB of the widened difference is the borrow out
  assign w_diff = {1'b0, r_acc} - {1'b0, w_s};
  assign io_bus.id_ready = r_state == IDLE;
  assign io_bus.busy = r_state == EXEC;
  assign io_bus.halted = r_state == HALT;
  assign io_bus.illegal = r_state == EXEC && w_op >= 4'hA && w_op <= 4'hE;
  assign io_bus.rd_data = r_regs[io_bus.rd_addr];
  assign io_bus.acc = r_acc;
  assign io_bus.zero = r_zero;
  assign io_bus.carry = r_carry;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = io_bus.id_valid ? EXEC : IDLE;
      EXEC: w_next = w_op == 4'hF ? HALT : IDLE;
      default: w_next = HALT;
    endcase
  end
  always_comb begin
    w_acc = r_acc;
    w_carry = r_carry;
    w_we = 1'b0;
    w_wd = r_acc;
    w_upd_z = 1'b0;
    case (w_op)
      4'h1: begin w_we = 1'b1; w_wd = w_imm; end
      4'h2: begin w_we = 1'b1; w_wd = w_s; end
      4'h3: begin w_acc = w_s; w_upd_z = 1'b1; end
      4'h4: w_we = 1'b1;
      4'h5: begin {w_carry, w_acc} = w_sum; w_upd_z = 1'b1; end
      4'h6: begin {w_carry, w_acc} = w_diff; w_upd_z = 1'b1; end
      4'h7: begin w_acc = r_acc & w_s; w_upd_z = 1'b1; end
      4'h8: begin w_acc = r_acc | w_s; w_upd_z = 1'b1; end
      4'h9: begin w_acc = r_acc ^ w_s; w_upd_z = 1'b1; end
      default: ;
    endcase
    w_zero = w_upd_z ? w_acc == '0 : r_zero;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ir <= '0;
      r_acc <= '0;
      r_zero <= 1'b0;
      r_carry <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && io_bus.id_valid) r_ir <= io_bus.id;
      if (r_state == EXEC) begin
        r_acc <= w_acc;
        r_zero <= w_zero;
        r_carry <= w_carry;
        if (w_we) r_regs[w_dst] <= w_wd;
      end
    end
  end
endmodule

// File: tb/tb_instr_exec_unit.sv
// tb_instr_exec_unit: directed self-checking bench for instr_exec_unit (DW=8, NREG=8)
module tb_instr_exec_unit;
  logic clk, rst;
  int tests = 0;
  int fails = 0;
  logic [7:0] v;
  instr_exec_unit_if #(.DW(8), .NREG(8)) bus ();
  instr_exec_unit #(.DW(8), .NREG(8)) dut (.clk(clk), .rst(rst), .io_bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic rd(input int a, output logic [7:0] d);
    bus.rd_addr = a[2:0];
    #1;
    d = bus.rd_data;
  endtask
  task automatic exec_instr(input logic [17:0] ins);
    bus.id = ins;
    bus.id_valid = 1;
    @(posedge clk);
    #1;
    bus.id_valid = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1;
    bus.id_valid = 0;
    bus.id = '0;
    bus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    tests++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", bus.id_ready); end
    tests++; if ({bus.busy, bus.halted, bus.illegal} !== 3'b000) begin fails++; $display("FAIL reset_status got %b exp 000", {bus.busy, bus.halted, bus.illegal}); end
    tests++; if ({bus.acc, bus.zero, bus.carry} !== 10'h0) begin fails++; $display("FAIL reset_acc_flags got %h exp 0", {bus.acc, bus.zero, bus.carry}); end
    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      tests++; if (v !== 8'h00) begin fails++; $display("FAIL reset_reg%0d got %h exp 00", i, v); end
    end
  endtask
  task automatic test_movi;
    bus.rd_addr = 3'd4;
    bus.id = 18'b0001_100_000_11011000;
    bus.id_valid = 1;
    @(posedge clk);
    #1;
    bus.id_valid = 0;
    tests++; if ({bus.busy, bus.id_ready} !== 2'b10) begin fails++; $display("FAIL movi_exec_state got %b exp 10", {bus.busy, bus.id_ready}); end
    tests++; if (bus.rd_data !== 8'h00) begin fails++; $display("FAIL movi_early got %h exp 00", bus.rd_data); end
    @(posedge clk);
    #1;
    tests++; if ({bus.busy, bus.id_ready} !== 2'b01) begin fails++; $display("FAIL movi_done_state got %b exp 01", {bus.busy, bus.id_ready}); end
    tests++; if (bus.rd_data !== 8'hD8) begin fails++; $display("FAIL movi_r4 got %h exp d8", bus.rd_data); end
  endtask
  task automatic test_mov_lda;
    exec_instr(18'b0010_011_100_00000000);
    rd(3, v);
    tests++; if (v !== 8'hD8) begin fails++; $display("FAIL mov_r3 got %h exp d8", v); end
    exec_instr(18'b0011_000_011_00000000);
    tests++; if ({bus.acc, bus.zero, bus.carry} !== {8'hD8, 2'b00}) begin fails++; $display("FAIL lda got acc=%h z=%b c=%b exp acc=d8 z=0 c=0", bus.acc, bus.zero, bus.carry); end
  endtask
  task automatic test_add_sub;
    exec_instr(18'b0001_101_000_00101000);
    exec_instr(18'b0101_000_101_00000000);
    tests++; if ({bus.acc, bus.zero, bus.carry} !== {8'h00, 2'b11}) begin fails++; $display("FAIL add got acc=%h z=%b c=%b exp acc=00 z=1 c=1", bus.acc, bus.zero, bus.carry); end
    exec_instr(18'b0110_000_101_00000000);
    tests++; if ({bus.acc, bus.zero, bus.carry} !== {8'hD8, 2'b01}) begin fails++; $display("FAIL sub got acc=%h z=%b c=%b exp acc=d8 z=0 c=1", bus.acc, bus.zero, bus.carry); end
  endtask
  task automatic test_logic;
    exec_instr(18'b0001_110_000_00001111);
    exec_instr(18'b0111_000_110_00000000);
    tests++; if ({bus.acc, bus.zero, bus.carry} !== {8'h08, 2'b01}) begin fails++; $display("FAIL and got acc=%h z=%b c=%b exp acc=08 z=0 c=1", bus.acc, bus.zero, bus.carry); end
    exec_instr(18'b1000_000_110_00000000);
    tests++; if (bus.acc !== 8'h0F) begin fails++; $display("FAIL or got %h exp 0f", bus.acc); end
    exec_instr(18'b0100_111_000_00000000);
    rd(7, v);
    tests++; if (v !== 8'h0F) begin fails++; $display("FAIL sta_r7 got %h exp 0f", v); end
    exec_instr(18'b0010_111_111_00000000);
    rd(7, v);
    tests++; if (v !== 8'h0F) begin fails++; $display("FAIL mov_self got %h exp 0f", v); end
    exec_instr(18'b1001_000_110_00000000);
    tests++; if ({bus.acc, bus.zero, bus.carry} !== {8'h00, 2'b11}) begin fails++; $display("FAIL xor got acc=%h z=%b c=%b exp acc=00 z=1 c=1", bus.acc, bus.zero, bus.carry); end
  endtask
  task automatic test_illegal;
    bus.id = 18'b1011_100_100_11111111;
    bus.id_valid = 1;
    @(posedge clk);
    #1;
    bus.id_valid = 0;
    tests++; if (bus.illegal !== 1'b1) begin fails++; $display("FAIL illegal_pulse got %b exp 1", bus.illegal); end
    @(posedge clk);
    #1;
    tests++; if ({bus.illegal, bus.id_ready} !== 2'b01) begin fails++; $display("FAIL illegal_after got %b exp 01", {bus.illegal, bus.id_ready}); end
    tests++; if ({bus.acc, bus.zero, bus.carry} !== {8'h00, 2'b11}) begin fails++; $display("FAIL illegal_acc got acc=%h z=%b c=%b exp acc=00 z=1 c=1", bus.acc, bus.zero, bus.carry); end
    rd(4, v);
    tests++; if (v !== 8'hD8) begin fails++; $display("FAIL illegal_r4 got %h exp d8", v); end
  endtask
  task automatic test_back_to_back;
    bus.id = 18'b0001_001_000_00010001;
    bus.id_valid = 1;
    @(posedge clk);
    #1;
    bus.id = 18'b0001_010_000_00100010;
    @(posedge clk);
    #1;
    rd(1, v);
    tests++; if (v !== 8'h11) begin fails++; $display("FAIL b2b_r1 got %h exp 11", v); end
    tests++; if (bus.id_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b exp 1", bus.id_ready); end
    @(posedge clk);
    #1;
    bus.id_valid = 0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b exp 1", bus.busy); end
    @(posedge clk);
    #1;
    rd(2, v);
    tests++; if (v !== 8'h22) begin fails++; $display("FAIL b2b_r2 got %h exp 22", v); end
  endtask
  task automatic test_reset_mid_exec;
    bus.id = 18'b0001_010_000_01110111;
    bus.id_valid = 1;
    @(posedge clk);
    #1;
    bus.id_valid = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    rd(2, v);
    tests++; if (v !== 8'h00) begin fails++; $display("FAIL midrst_r2 got %h exp 00", v); end
    tests++; if ({bus.busy, bus.id_ready} !== 2'b01) begin fails++; $display("FAIL midrst_state got %b exp 01", {bus.busy, bus.id_ready}); end
    @(posedge clk);
    #1;
    rd(2, v);
    tests++; if (v !== 8'h00) begin fails++; $display("FAIL midrst_r2_later got %h exp 00", v); end
  endtask
  task automatic test_halt;
    exec_instr(18'b0001_011_000_10011010);
    exec_instr(18'b0011_000_011_00000000);
    exec_instr(18'b1111_000_000_00000000);
    tests++; if ({bus.halted, bus.id_ready, bus.busy} !== 3'b100) begin fails++; $display("FAIL halt_state got %b exp 100", {bus.halted, bus.id_ready, bus.busy}); end
    bus.id = 18'b0001_001_000_01010101;
    bus.id_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tests++; if ({bus.halted, bus.id_ready, bus.busy} !== 3'b100) begin fails++; $display("FAIL halt_hold%0d got %b exp 100", i, {bus.halted, bus.id_ready, bus.busy}); end
    end
    bus.id_valid = 0;
    rd(1, v);
    tests++; if (v !== 8'h00) begin fails++; $display("FAIL halt_r1 got %h exp 00", v); end
    tests++; if (bus.acc !== 8'h9A) begin fails++; $display("FAIL halt_acc got %h exp 9a", bus.acc); end
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    tests++; if ({bus.halted, bus.id_ready} !== 2'b01) begin fails++; $display("FAIL halt_rst_state got %b exp 01", {bus.halted, bus.id_ready}); end
    tests++; if (bus.acc !== 8'h00) begin fails++; $display("FAIL halt_rst_acc got %h exp 00", bus.acc); end
    rd(3, v);
    tests++; if (v !== 8'h00) begin fails++; $display("FAIL halt_rst_r3 got %h exp 00", v); end
  endtask
  initial begin
    test_reset;
    test_movi;
    test_mov_lda;
    test_add_sub;
    test_logic;
    test_illegal;
    test_back_to_back;
    test_reset_mid_exec;
    test_halt;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_exec_unit.md
INSTR_EXEC_UNIT -- requirements
Module: instr_exec_unit

Interface
REQ-001 Parameter DW, default 8: data width of registers, accumulator and immediate field.
REQ-002 Parameter NREG, default 8: number of general registers, power of two, >= 2.
REQ-003 Derived constants: RAW = clog2(NREG); IW = 4 + 2*RAW + DW. Defaults give IW = 18.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 id  in  IW  instruction word, with fields:
- opcode = id[IW-1:IW-4]
- dst = next RAW bits
- src = next RAW bits
- imm = id[DW-1:0]
REQ-007 id_valid  in  1  instruction present on id.
REQ-008 id_ready  out  1  unit can accept an instruction.
REQ-009 rd_addr  in  RAW  debug read select.
REQ-010 rd_data  out  DW  combinational value of R[rd_addr].
REQ-011 acc  out  DW  accumulator.
REQ-012 zero, carry  out  1 each  flags.
REQ-013 busy  out  1  high in EXEC.
REQ-014 halted  out  1  high in HALT.
REQ-015 illegal  out  1  one-cycle pulse on an undefined opcode.

Function
REQ-016 States: IDLE, EXEC, HALT.
- id_ready = 1 only in IDLE.
- An instruction is accepted when id_valid and id_ready are both high on a clock edge.
REQ-017 On accept, latch id and go IDLE -> EXEC.
- EXEC performs the operation (register, accumulator and flag updates) on its edge, then returns to IDLE.
- Throughput: one instruction per 2 cycles.
- Results are visible the cycle after EXEC.
REQ-018 Opcodes (all arithmetic is modulo 2^DW):
- 0000 NOP
- 0001 MOVI: R[dst] <= imm
- 0010 MOV: R[dst] <= R[src]
- 0011 LDA: acc <= R[src]
- 0100 STA: R[dst] <= acc
- 0101 ADD: acc <= acc + R[src]; carry = carry-out
- 0110 SUB: acc <= acc - R[src]; carry = borrow
- 0111 AND, 1000 OR, 1001 XOR: acc <= acc op R[src]
- 1111 HALT
REQ-019 zero is updated by LDA, ADD, SUB, AND, OR, XOR to (new acc == 0).
- carry is updated only by ADD and SUB.
- All other opcodes leave both flags unchanged.
REQ-020 Opcodes 1010-1110:
- No state change other than the illegal pulse in the EXEC cycle.
- Unit returns to IDLE.
REQ-021 HALT: EXEC -> HALT; id_ready = 0 and id_valid is ignored until rst.
REQ-022 id_valid while not ready: the instruction is not consumed, and the source must hold it.
REQ-023 MOV with dst == src leaves R[dst] unchanged. rd_data reflects a write from the cycle after EXEC.
REQ-024 With DW = 16 and NREG = 16, the imm field is 16 bits and IW = 28; behaviour is otherwise identical.

Reset
REQ-025 rst high at an edge, in any state including mid-EXEC:
- all R[i], acc, zero, carry <= 0
- state <= IDLE, so id_ready = 1 and busy = halted = illegal = 0
- any in-flight instruction is discarded.
REQ-026 rst has priority over accept and execute in the same cycle.

Verification
REQ-027 Directed scenarios (defaults DW = 8, NREG = 8):
- id = 18'b0001_100_000_11011000 (MOVI R4, 0xD8), valid 1 cycle -> rd_addr = 4 gives rd_data = 0xD8 two edges after accept; busy high for 1 cycle.
- Then 0010_011_100_xx (MOV R3 <- R4), then 0011_000_011_xx (LDA R3) -> R3 = 0xD8, acc = 0xD8, zero = 0.
- Then 0101 ADD R5 with R5 = 0x28 -> acc = 0x00, carry = 1, zero = 1. Then SUB R5 -> acc = 0xD8, carry = 1 (borrow).
- Then HALT -> halted = 1, id_ready = 0; a following MOVI R1, 0x55 held valid 4 cycles -> R1 = 0x00; rst -> halted = 0, all registers 0.
- Opcode 1011 -> illegal pulses exactly 1 cycle; acc and registers unchanged; id_ready returns high.
- rst asserted during the EXEC of MOVI R2, 0x77 -> R2 = 0x00, state IDLE next cycle.
